des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_key_schedule.sv | 161 ++++++++++++++++
 tb/tb_des_key_schedule.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// DES key schedule: accepts a PC-1-permuted 56-bit key and streams the
// sixteen 48-bit round subkeys over a valid/ready interface, either in
// encryption order (K1..K16) or decryption order (K16..K1).

// PC-2 selection of 48 bits out of the 56-bit {D,C} register pair.
// cd bit n-1 carries DES key-schedule bit n; subkey bit j-1 carries PC-2 output j.
module permuted_choice_2 (
    input  logic [55:0] cd,
    output logic [47:0] k
);

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    for (genvar j = 0; j < 48; j++) begin : g_pc2
        assign k[j] = cd[PC2_TAB[j] - 1];
    end

endmodule

module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [55:0] key_in,
    input  logic        decrypt,
    input  logic        abort,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] subkey,
    output logic [3:0]  sk_round,
    output logic        sk_last
);

    typedef enum logic {IDLE, GEN} state_t;

    state_t      state;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic        dec_q;

    // Encrypt shift amount for 0-based round index; decrypt reuses it mirrored.
    function automatic logic [1:0] shift_amt(input logic [3:0] idx);
        logic [1:0] n;
        case (idx)
            4'd0, 4'd1, 4'd8, 4'd15: n = 2'd1;
            default:                 n = 2'd2;
        endcase
        return n;
    endfunction

    // Bit i takes bit i+n: DES bit 1 wraps around to bit 28.
    function automatic logic [27:0] rot_left(input logic [27:0] v, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {v[0],   v[27:1]};
            2'd2:    r = {v[1:0], v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Bit i takes bit i-n: DES bit 28 wraps around to bit 1.
    function automatic logic [27:0] rot_right(input logic [27:0] v, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {v[26:0], v[27]};
            2'd2:    r = {v[25:0], v[27:26]};
            default: r = v;
        endcase
        return r;
    endfunction

    logic [1:0] enc_step;
    logic [1:0] dec_step;

    assign enc_step = shift_amt(sk_round + 4'd1);
    assign dec_step = shift_amt(4'd15 - sk_round);

    // Outputs come purely from registers, so nothing upstream leaks through.
    permuted_choice_2 u_pc2 (
        .cd ({d_q, c_q}),
        .k  (subkey)
    );

    assign sk_last = sk_valid & (sk_round == 4'd15);

    // Control FSM plus C/D rotation registers; abort outranks any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            dec_q     <= 1'b0;
            sk_round  <= '0;
            sk_valid  <= 1'b0;
            key_ready <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            sk_valid  <= 1'b0;
            sk_round  <= '0;
            key_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid && key_ready) begin
                        // Decrypt starts at K16 = C16/D16 = C0/D0 (total shift is 28).
                        if (decrypt) begin
                            c_q <= key_in[27:0];
                            d_q <= key_in[55:28];
                        end else begin
                            c_q <= rot_left(key_in[27:0], 2'd1);
                            d_q <= rot_left(key_in[55:28], 2'd1);
                        end
                        dec_q     <= decrypt;
                        sk_round  <= '0;
                        sk_valid  <= 1'b1;
                        key_ready <= 1'b0;
                        state     <= GEN;
                    end else begin
                        key_ready <= 1'b1;
                    end
                end
                GEN: begin
                    if (sk_valid && sk_ready) begin
                        if (sk_round == 4'd15) begin
                            sk_valid  <= 1'b0;
                            sk_round  <= '0;
                            key_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            if (dec_q) begin
                                c_q <= rot_right(c_q, dec_step);
                                d_q <= rot_right(d_q, dec_step);
                            end else begin
                                c_q <= rot_left(c_q, enc_step);
                                d_q <= rot_left(d_q, enc_step);
                            end
                            sk_round <= sk_round + 4'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    sk_valid  <= 1'b0;
                    key_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: hand-computed subkeys for a single-bit
// key, an independent cumulative-shift model for a random key, and checks of
// stall, abort and mid-schedule reset behaviour.
module tb_des_key_schedule;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [55:0] key_in;
    logic        decrypt;
    logic        abort;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] subkey;
    logic [3:0]  sk_round;
    logic        sk_last;

    int checks;
    int failures;

    logic [47:0] cap [16];
    logic [47:0] enc [16];

    int pc2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };
    int sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .abort     (abort),
        .sk_valid  (sk_valid),
        .sk_ready  (sk_ready),
        .subkey    (subkey),
        .sk_round  (sk_round),
        .sk_last   (sk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // K(r+1) from the original key using the cumulative shift count.
    function automatic logic [47:0] model_sk(input logic [55:0] key, input int r);
        logic [27:0] c0;
        logic [27:0] d0;
        logic [55:0] cd;
        logic [47:0] k;
        int s;
        c0 = key[27:0];
        d0 = key[55:28];
        s = 0;
        for (int i = 0; i <= r; i++) s += sh[i];
        cd = '0;
        for (int i = 0; i < 28; i++) begin
            if (((c0 >> ((i + s) % 28)) & 28'd1) != 28'd0) cd |= 56'd1 << i;
            if (((d0 >> ((i + s) % 28)) & 28'd1) != 28'd0) cd |= 56'd1 << (i + 28);
        end
        k = '0;
        for (int j = 0; j < 48; j++)
            if (((cd >> (pc2[j] - 1)) & 56'd1) != 56'd0) k |= 48'd1 << j;
        return k;
    endfunction

    task automatic load_key(input logic [55:0] key, input logic dec);
        int n;
        n = 0;
        while (!key_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("key_ready_before_load", 64'(key_ready), 64'd1);
        key_in    = key;
        decrypt   = dec;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        chk("sk_valid_latency1", 64'(sk_valid), 64'd1);
        chk("sk_round_start", 64'(sk_round), 64'd0);
        chk("key_ready_in_gen", 64'(key_ready), 64'd0);
    endtask

    task automatic run_sched(input logic [55:0] key, input logic dec, input bit rnd);
        int hs;
        int cyc;
        bit stalled;
        logic [47:0] pk;
        logic [3:0]  pr;
        load_key(key, dec);
        hs = 0;
        cyc = 0;
        stalled = 1'b0;
        pk = '0;
        pr = '0;
        while (hs < 16 && cyc < 200) begin
            chk("sk_valid_in_gen", 64'(sk_valid), 64'd1);
            if (sk_valid) begin
                if (stalled) begin
                    chk("stall_subkey_hold", 64'(subkey), 64'(pk));
                    chk("stall_round_hold", 64'(sk_round), 64'(pr));
                end
                chk("sk_round_seq", 64'(sk_round), 64'(hs));
                chk("sk_last", 64'(sk_last), 64'(hs == 15));
                sk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (sk_ready) begin
                    cap[hs[3:0]] = subkey;
                    hs++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pk = subkey;
                    pr = sk_round;
                end
            end
            @(negedge clk);
            cyc++;
        end
        sk_ready = 1'b0;
        chk("handshake_count", 64'(hs), 64'd16);
        chk("sk_valid_after_last", 64'(sk_valid), 64'd0);
        chk("key_ready_after_last", 64'(key_ready), 64'd1);
    endtask

    task automatic run_to_round(input logic [3:0] r);
        int n;
        n = 0;
        sk_ready = 1'b1;
        while (sk_round != r && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("reach_round", 64'(sk_round), 64'(r));
    endtask

    initial begin
        logic [55:0] rkey;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        decrypt   = 1'b0;
        abort     = 1'b0;
        sk_ready  = 1'b0;

        // Reset state
        #3;
        chk("rst_key_ready", 64'(key_ready), 64'd0);
        chk("rst_sk_valid", 64'(sk_valid), 64'd0);
        chk("rst_sk_last", 64'(sk_last), 64'd0);
        chk("rst_sk_round", 64'(sk_round), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("key_ready_before_edge", 64'(key_ready), 64'd0);
        @(negedge clk);
        chk("key_ready_after_release", 64'(key_ready), 64'd1);

        // Abort in IDLE blocks the key offer
        key_in    = 56'h1;
        key_valid = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        abort     = 1'b0;
        chk("idle_abort_no_accept", 64'(sk_valid), 64'd0);
        chk("idle_abort_key_ready", 64'(key_ready), 64'd1);

        // Single-bit key, encrypt order
        run_sched(56'h1, 1'b0, 1'b0);
        chk("enc1_k1", 64'(cap[0]), 64'h000000000080);
        chk("enc1_k2", 64'(cap[1]), 64'h000000100000);
        chk("enc1_k15", 64'(cap[14]), 64'h000000800000);
        chk("enc1_k16", 64'(cap[15]), 64'h000000000010);

        // Single-bit key, decrypt order
        run_sched(56'h1, 1'b1, 1'b0);
        chk("dec1_k16", 64'(cap[0]), 64'h000000000010);
        chk("dec1_k15", 64'(cap[1]), 64'h000000800000);
        chk("dec1_k1", 64'(cap[15]), 64'h000000000080);

        // Random key: encrypt against model, decrypt (stalled) against reversed encrypt
        rkey = {$urandom(), $urandom()} & 56'hFF_FFFF_FFFF_FFFF;
        run_sched(rkey, 1'b0, 1'b0);
        for (int r = 0; r < 16; r++) begin
            enc[r] = cap[r];
            chk($sformatf("enc_model_r%0d", r), 64'(cap[r]), 64'(model_sk(rkey, r)));
        end
        run_sched(rkey, 1'b1, 1'b1);
        for (int r = 0; r < 16; r++)
            chk($sformatf("dec_reverse_r%0d", r), 64'(cap[r]), 64'(enc[15 - r]));

        // Abort at round 7 alongside a subkey handshake
        load_key(rkey ^ 56'h5A5A_A5A5_0F0F_F0, 1'b0);
        run_to_round(4'd7);
        abort = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        sk_ready = 1'b0;
        chk("abort_sk_valid", 64'(sk_valid), 64'd0);
        chk("abort_key_ready", 64'(key_ready), 64'd1);
        chk("abort_sk_round", 64'(sk_round), 64'd0);
        run_sched(56'h1, 1'b0, 1'b0);
        chk("restart_k1", 64'(cap[0]), 64'h000000000080);

        // Reset pulsed mid-schedule at round 5
        load_key(rkey, 1'b1);
        run_to_round(4'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sk_valid", 64'(sk_valid), 64'd0);
        chk("async_rst_sk_round", 64'(sk_round), 64'd0);
        chk("async_rst_subkey", 64'(subkey), 64'd0);
        chk("async_rst_key_ready", 64'(key_ready), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        sk_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_key_ready", 64'(key_ready), 64'd1);
        chk("post_rst_sk_valid", 64'(sk_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
